vga_image_scanner: RTL and testbench



---
 rtl/vga_image_scanner.sv | 151 +++++++++++++++
 tb/tb_vga_image_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_image_scanner.sv
// vga_image_scanner
// Generates 640x480@60 VGA timing from clk, addresses the image memory with
// vgaAdress, and turns the returned grayscale byte into RGB332 with active-low
// syncs. Pixels outside the IMG_W x IMG_H window are driven black.
//
// Ports
//   clk, rst_n           system clock, async active-low reset
//   vgaAdress   [18:0]   registered read address (index of the current pixel)
//   ImageData   [7:0]    memory data, valid RD_LAT clocks after vgaAdress
//   vga_r/g/b            RGB332 (r=g=data[7:5], b=data[7:6])
//   vga_hsync/vsync      active-low syncs, aligned with RGB
//   frame_start          one-clock pulse with the output of pixel (0,0)
module vga_image_scanner #(
  parameter int CLK_DIV = 2,
  parameter int RD_LAT  = 1,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] vgaAdress,
  input  logic [7:0]  ImageData,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_SYNC_BEG  = 10'd656;
  localparam logic [9:0] H_SYNC_END  = 10'd751;
  localparam logic [9:0] V_LAST      = 10'd524;
  localparam logic [9:0] V_SYNC_BEG  = 10'd490;
  localparam logic [9:0] V_SYNC_END  = 10'd491;
  localparam logic [9:0] IMG_W_C     = 10'(IMG_W);
  localparam logic [9:0] IMG_H_C     = 10'(IMG_H);
  // Explicit compare keeps the wrap correct even for a full 2^19 image.
  localparam logic [18:0] ADDR_LAST  = 19'(IMG_W * IMG_H - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [18:0]      addr_q, addr_d;
  logic             pix_ce;
  logic             in_img, hs, vs, first, entry;

  // Per-pixel flags {valid, img, hs, vs, first}, delayed to meet the data.
  logic [4:0]               stage_in;
  logic [RD_LAT-1:0][4:0]   pipe_q, pipe_d;
  logic [RD_LAT:0][4:0]     chain;
  logic [4:0]               cap;
  logic                     cap_ce;

  logic [2:0] r_q, r_d, g_q, g_d;
  logic [1:0] b_q, b_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  logic       unused_bits;

  assign unused_bits = ^ImageData[4:0];

  assign pix_ce = (div_q == DIV_LAST);
  assign in_img = (h_q < IMG_W_C) && (v_q < IMG_H_C);
  assign hs     = (h_q >= H_SYNC_BEG) && (h_q <= H_SYNC_END);
  assign vs     = (v_q >= V_SYNC_BEG) && (v_q <= V_SYNC_END);
  assign first  = (h_q == 10'd0) && (v_q == 10'd0);
  // div_q is 0 on the first clock of every pixel (including right after
  // reset), so the flags enter the pipe while the counters show that pixel.
  assign entry  = (div_q == '0);

  assign stage_in = {entry, in_img, hs, vs, first};
  assign chain    = {pipe_q, stage_in};
  assign pipe_d   = chain[RD_LAT-1:0];
  assign cap      = pipe_q[RD_LAT-1];
  assign cap_ce   = cap[4];

  always_comb begin
    div_d  = pix_ce ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      if (in_img) begin
        addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 19'd1;
      end
    end
  end

  always_comb begin
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    fs_d    = 1'b0;
    if (cap_ce) begin
      r_d     = cap[3] ? ImageData[7:5] : 3'd0;
      g_d     = cap[3] ? ImageData[7:5] : 3'd0;
      b_d     = cap[3] ? ImageData[7:6] : 2'd0;
      hsync_d = ~cap[2];
      vsync_d = ~cap[1];
      fs_d    = cap[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      pipe_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign vgaAdress   = addr_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner: two instances (small 4x3 image at the default
// rate, and a CLK_DIV=4/RD_LAT=3 full-size image) compared every clock
// against a pixel-index reference model.
module tb_vga_image_scanner;

  localparam int A_DIV = 2, A_LAT = 1, A_W = 4,   A_H = 3;
  localparam int B_DIV = 4, B_LAT = 3, B_W = 640, B_H = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic [2:0]  a_r, a_g, b_r, b_g;
  logic [1:0]  a_b, b_b;
  logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;

  vga_image_scanner #(.CLK_DIV(A_DIV), .RD_LAT(A_LAT), .IMG_W(A_W), .IMG_H(A_H)) u_a (
    .clk(clk), .rst_n(rst_n), .vgaAdress(a_addr), .ImageData(a_data),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_start(a_fs));

  vga_image_scanner #(.CLK_DIV(B_DIV), .RD_LAT(B_LAT), .IMG_W(B_W), .IMG_H(B_H)) u_b (
    .clk(clk), .rst_n(rst_n), .vgaAdress(b_addr), .ImageData(b_data),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_start(b_fs));

  // Memory contents selected by mode: 0 random table, 1 all 0xFF, 2 all 0xA5,
  // 3 low address byte.
  int         mode = 0;
  logic [7:0] rand_tab [256];

  function automatic logic [7:0] mem_f(input int m, input logic [18:0] a);
    case (m)
      1:       return 8'hFF;
      2:       return 8'hA5;
      3:       return a[7:0];
      default: return rand_tab[a[7:0]];
    endcase
  endfunction

  // Memory read models with RD_LAT register stages.
  logic [7:0] a_dq [A_LAT];
  logic [7:0] b_dq [B_LAT];
  always @(posedge clk) begin
    a_dq[0] <= mem_f(mode, a_addr);
    for (int i = 1; i < A_LAT; i++) a_dq[i] <= a_dq[i-1];
    b_dq[0] <= mem_f(mode, b_addr);
    for (int i = 1; i < B_LAT; i++) b_dq[i] <= b_dq[i-1];
  end
  assign a_data = a_dq[A_LAT-1];
  assign b_data = b_dq[B_LAT-1];

  // Image index of pixel (h,v): count of window pixels before it this frame.
  function automatic int addr_of(input int h, input int v, input int iw, input int ih);
    int c;
    if (v < ih) c = v * iw + ((h < iw) ? h : iw);
    else        c = 0;
    return c % (iw * ih);
  endfunction

  // Expected {addr, r, g, b, hsync, vsync, frame_start} t clocks after release.
  function automatic logic [29:0] exp_vec(input int t, input int cdiv, input int rdl,
                                          input int iw, input int ih);
    int p, h, v, ot;
    logic [18:0] a;
    logic [7:0]  d;
    logic [2:0]  r, g;
    logic [1:0]  b;
    logic        hsn, vsn, fs;
    p = t / cdiv;
    h = p % 800;
    v = (p / 800) % 525;
    a = 19'(addr_of(h, v, iw, ih));
    r = '0; g = '0; b = '0; hsn = 1'b1; vsn = 1'b1; fs = 1'b0;
    if (t >= rdl + 1) begin
      ot = t - rdl - 1;
      p = ot / cdiv;
      h = p % 800;
      v = (p / 800) % 525;
      d = mem_f(mode, 19'(addr_of(h, v, iw, ih)));
      if (h < iw && v < ih) begin
        r = d[7:5]; g = d[7:5]; b = d[7:6];
      end
      hsn = !(h >= 656 && h <= 751);
      vsn = !(v >= 490 && v <= 491);
      fs  = (h == 0) && (v == 0) && ((ot % cdiv) == 0);
    end
    return {a, r, g, b, hsn, vsn, fs};
  endfunction

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input int t, input logic [29:0] obs,
                       input logic [29:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
  endtask

  int a_hw, a_lp, b_hw, b_lp, a_fs_t, b_fs_t;

  task automatic run_phase(input int m, input int ncyc);
    logic [29:0] rst_vec;
    int a_f1, a_f2, b_f1, b_f2;
    logic a_prev, b_prev;
    rst_vec = {19'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    rst_n = 1'b0;
    mode  = m;
    #1;
    check("a_reset", 0, {a_addr, a_r, a_g, a_b, a_hs, a_vs, a_fs}, rst_vec);
    check("b_reset", 0, {b_addr, b_r, b_g, b_b, b_hs, b_vs, b_fs}, rst_vec);
    repeat ($urandom_range(2, 9)) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("a_t0", 0, {a_addr, a_r, a_g, a_b, a_hs, a_vs, a_fs}, exp_vec(0, A_DIV, A_LAT, A_W, A_H));
    check("b_t0", 0, {b_addr, b_r, b_g, b_b, b_hs, b_vs, b_fs}, exp_vec(0, B_DIV, B_LAT, B_W, B_H));
    a_hw = -1; a_lp = -1; b_hw = -1; b_lp = -1; a_fs_t = -1; b_fs_t = -1;
    a_f1 = -1; a_f2 = -1; b_f1 = -1; b_f2 = -1;
    a_prev = a_hs; b_prev = b_hs;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      check("a_pix", t, {a_addr, a_r, a_g, a_b, a_hs, a_vs, a_fs}, exp_vec(t, A_DIV, A_LAT, A_W, A_H));
      check("b_pix", t, {b_addr, b_r, b_g, b_b, b_hs, b_vs, b_fs}, exp_vec(t, B_DIV, B_LAT, B_W, B_H));
      if (m == 3 && t == (2 * 800 + 3) * A_DIV)
        check("a_addr_last", t, 30'(a_addr), 30'd11);
      if (m == 3 && t == (2 * 800 + 4) * A_DIV)
        check("a_addr_wrap", t, 30'(a_addr), 30'd0);
      if (a_fs && a_fs_t < 0) a_fs_t = t;
      if (b_fs && b_fs_t < 0) b_fs_t = t;
      if (a_prev && !a_hs) begin
        if (a_f1 < 0) a_f1 = t; else if (a_f2 < 0) a_f2 = t;
      end
      if (!a_prev && a_hs && a_hw < 0 && a_f1 >= 0) a_hw = t - a_f1;
      if (b_prev && !b_hs) begin
        if (b_f1 < 0) b_f1 = t; else if (b_f2 < 0) b_f2 = t;
      end
      if (!b_prev && b_hs && b_hw < 0 && b_f1 >= 0) b_hw = t - b_f1;
      a_prev = a_hs;
      b_prev = b_hs;
    end
    if (a_f2 >= 0) a_lp = a_f2 - a_f1;
    if (b_f2 >= 0) b_lp = b_f2 - b_f1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rand_tab[i] = 8'($urandom);

    run_phase(3, 5000);
    check("a_fs_latency", 0, 30'(a_fs_t), 30'(A_LAT + 1));
    check("b_fs_latency", 0, 30'(b_fs_t), 30'(B_LAT + 1));

    run_phase(1, 3400);
    run_phase(2, 400);

    run_phase(0, 7000);
    check("a_hsync_width", 0, 30'(a_hw), 30'd192);
    check("a_line_period", 0, 30'(a_lp), 30'd1600);
    check("b_hsync_width", 0, 30'(b_hw), 30'd384);
    check("b_line_period", 0, 30'(b_lp), 30'd3200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
